// File: rtl/uart_flash_loader_pkg.sv
// Shared types and constants for the UART-to-flash image loader.
package uart_flash_loader_pkg;

   localparam int PAGE_SIZE = 256;
   localparam int PAGE_BITS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ERASE,
      S_PROG,
      S_NEXT
   } wr_state_t;

   typedef enum logic [1:0] {
      BANK_FREE,
      BANK_FILLING,
      BANK_READY
   } bank_state_t;

   // Page-aligned base of an arbitrary flash address.
   function automatic logic [23:0] page_base(input logic [23:0] addr);
      return {addr[23:PAGE_BITS], {PAGE_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/loader_page_ram.sv
// 512x8 simple dual-port RAM holding both page banks; address bit 8 is the bank.
module loader_page_ram (
   input  logic       clk,
   input  logic       we,
   input  logic [8:0] waddr,
   input  logic [7:0] wdata,
   input  logic [8:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [512];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/uart_flash_loader.sv
// Collects UART bytes into ping-pong page banks and drives the flash
// sector-erase and page-program handshakes for each filled bank.
//
// state   | meaning
// S_IDLE  | no session; waiting for start
// S_WAIT  | waiting for the oldest bank to become ready
// S_ERASE | sector erase held, waiting for ack
// S_PROG  | page program held, feeding bank bytes on data requests
// S_NEXT  | advance the program address by one page
module uart_flash_loader
   import uart_flash_loader_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 5_000_000,
   parameter int SECTOR_BITS  = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [23:0] start_addr,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        flash_sector_erase,
   output logic [23:0] flash_sector_addr,
   input  logic        flash_sector_erase_ack,
   output logic        flash_write,
   output logic [23:0] flash_write_addr,
   output logic [8:0]  flash_write_size,
   input  logic        flash_write_data_req,
   output logic [7:0]  flash_write_data_in,
   input  logic        flash_write_ack,
   output logic        busy,
   output logic        overflow,
   output logic [23:0] bytes_written
);

   localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_TIMEOUT);

   wr_state_t   state, state_nxt;

   logic        armed;
   bank_state_t bank_st  [2];
   logic [8:0]  bank_cnt [2];
   logic        fill_bank;
   logic [8:0]  fill_cnt;
   logic [IW-1:0] idle_left;
   logic        flush_pend;

   logic        wr_bank;
   logic [23:0] wr_addr;
   logic        first_page;
   logic [7:0]  rd_idx;

   logic        start_ok;
   logic        all_free;
   logic        idle_hit;
   logic        fill_open;
   logic        accept;
   logic        drop;
   logic        page_full;
   logic        flush_now;
   logic        disarm;
   logic        prog_done;

   logic [8:0]  ram_raddr;
   logic [7:0]  ram_rdata;
   logic        unused_low_addr;

   // The low byte of the start address is discarded by page alignment.
   assign unused_low_addr = ^start_addr[7:0];

   assign all_free  = (bank_st[0] == BANK_FREE) && (bank_st[1] == BANK_FREE);
   assign busy      = armed || !all_free || (state != S_IDLE);
   assign start_ok  = start && !busy;

   assign idle_hit  = armed && (idle_left == '0);
   assign fill_open = (bank_st[fill_bank] != BANK_READY);
   assign accept    = armed && rx_valid && fill_open;
   assign drop      = armed && rx_valid && !fill_open;
   assign page_full = accept && (fill_cnt == 9'd255);
   // A timeout that coincides with a byte is honoured on the next idle cycle.
   assign flush_now = armed && !rx_valid && (flush_pend || idle_hit) && (fill_cnt != 9'd0);
   // A full idle period with nothing pending ends the session.
   assign disarm    = idle_hit && !rx_valid && !flush_pend && (fill_cnt == 9'd0);
   assign prog_done = (state == S_PROG) && flash_write_ack;

   loader_page_ram u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr ({fill_bank, fill_cnt[7:0]}),
      .wdata (rx_data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Bank collector: session arming, idle timer, bank fill and hand-over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed       <= 1'b0;
         bank_st[0]  <= BANK_FREE;
         bank_st[1]  <= BANK_FREE;
         bank_cnt[0] <= '0;
         bank_cnt[1] <= '0;
         fill_bank   <= 1'b0;
         fill_cnt    <= '0;
         idle_left   <= IDLE_LOAD;
         flush_pend  <= 1'b0;
         overflow    <= 1'b0;
      end else if (start_ok) begin
         armed       <= 1'b1;
         bank_st[0]  <= BANK_FREE;
         bank_st[1]  <= BANK_FREE;
         fill_bank   <= 1'b0;
         fill_cnt    <= '0;
         idle_left   <= IDLE_LOAD;
         flush_pend  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (prog_done) begin
            bank_st[wr_bank] <= BANK_FREE;
         end

         if (armed && rx_valid) begin
            idle_left <= IDLE_LOAD;
         end else if (idle_left != '0) begin
            idle_left <= idle_left - IW'(1);
         end

         if (drop) begin
            overflow <= 1'b1;
         end

         if (accept) begin
            if (page_full) begin
               bank_st[fill_bank]  <= BANK_READY;
               bank_cnt[fill_bank] <= 9'd256;
               fill_bank           <= !fill_bank;
               fill_cnt            <= '0;
            end else begin
               bank_st[fill_bank]  <= BANK_FILLING;
               fill_cnt            <= fill_cnt + 9'd1;
            end
         end else if (flush_now) begin
            bank_st[fill_bank]  <= BANK_READY;
            bank_cnt[fill_bank] <= fill_cnt;
            fill_bank           <= !fill_bank;
            fill_cnt            <= '0;
         end

         if (rx_valid) begin
            flush_pend <= flush_pend || (idle_hit && accept);
         end else begin
            flush_pend <= 1'b0;
         end

         if (disarm) begin
            armed <= 1'b0;
         end
      end
   end

   // Writer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Writer next state and flash request outputs.
   always_comb begin
      state_nxt          = state;
      flash_sector_erase = 1'b0;
      flash_sector_addr  = '0;
      flash_write        = 1'b0;
      flash_write_addr   = '0;
      flash_write_size   = '0;
      ram_raddr          = {wr_bank, 8'h00};
      unique case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bank_st[wr_bank] == BANK_READY) begin
               if (first_page || (wr_addr[SECTOR_BITS-1:0] == '0)) begin
                  state_nxt = S_ERASE;
               end else begin
                  state_nxt = S_PROG;
               end
            end else if (!armed && all_free) begin
               state_nxt = S_IDLE;
            end
         end
         S_ERASE: begin
            flash_sector_erase = 1'b1;
            flash_sector_addr  = wr_addr;
            if (flash_sector_erase_ack) begin
               state_nxt = S_PROG;
            end
         end
         S_PROG: begin
            flash_write      = 1'b1;
            flash_write_addr = wr_addr;
            flash_write_size = bank_cnt[wr_bank];
            // Address the byte after the one being handed out so the
            // registered read keeps pace with back-to-back requests.
            ram_raddr        = {wr_bank, rd_idx + 8'(flash_write_data_req)};
            if (flash_write_ack) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            state_nxt = S_WAIT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Writer datapath: address tracking, byte feed and byte accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr             <= '0;
         first_page          <= 1'b0;
         wr_bank             <= 1'b0;
         rd_idx              <= '0;
         flash_write_data_in <= '0;
         bytes_written       <= '0;
      end else begin
         if (start_ok) begin
            wr_addr       <= page_base(start_addr);
            first_page    <= 1'b1;
            wr_bank       <= 1'b0;
            bytes_written <= '0;
         end
         unique case (state)
            S_ERASE: begin
               if (flash_sector_erase_ack) begin
                  first_page <= 1'b0;
               end
            end
            S_PROG: begin
               if (flash_write_data_req) begin
                  flash_write_data_in <= ram_rdata;
                  rd_idx              <= rd_idx + 8'd1;
               end
               if (flash_write_ack) begin
                  bytes_written <= bytes_written + 24'(bank_cnt[wr_bank]);
                  wr_bank       <= !wr_bank;
               end
            end
            S_NEXT: begin
               wr_addr <= wr_addr + 24'(PAGE_SIZE);
            end
            default: begin
            end
         endcase
         if (state != S_PROG) begin
            rd_idx <= '0;
         end
      end
   end

endmodule

// File: doc/uart_flash_loader.md
Name: uart_flash_loader

Overview:
- Upstream feeder for spi_flash_top. It consumes UART receive bytes and collects them in a ping-pong pair of 256-byte page buffers.
- It drives the flash sector-erase and page-program request/ack handshakes so a host can stream an image into SPI flash starting at a chosen address.
- It sits between the UART receiver and spi_flash_top. It owns only the erase and write ports; read and bulk-erase stay with their existing users.

Parameters:
- IDLE_TIMEOUT, 5_000_000: clk cycles with no rx_valid before a partially filled bank is flushed (100 ms at 50 MHz).
- SECTOR_BITS, 12: log2 of the erase sector size in bytes (4 KiB).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that arms a session; ignored while busy
- start_addr  in  24  session base address; bits [7:0] are forced to 0
- rx_data  in  8  UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- flash_sector_erase  out  1  erase request, held until ack
- flash_sector_addr  out  24  erase address
- flash_sector_erase_ack  in  1  erase complete
- flash_write  out  1  page program request, held until ack
- flash_write_addr  out  24  program address, always page aligned
- flash_write_size  out  9  bytes in this program, 1..256
- flash_write_data_req  in  1  flash core requests the next byte
- flash_write_data_in  out  8  byte supplied to the flash core
- flash_write_ack  in  1  program complete
- busy  out  1  session armed, or any bank not free
- overflow  out  1  sticky: a byte was dropped; cleared by start
- bytes_written  out  24  bytes programmed in this session; wraps

Behaviour:
- Reset values: all outputs 0; both banks free; state S_IDLE.
- Bank collector:
  - When armed, each rx_valid writes rx_data into the fill bank at fill_cnt, then fill_cnt increments.
  - A bank is marked ready when fill_cnt reaches 256, or when the idle counter reaches IDLE_TIMEOUT with fill_cnt > 0.
  - On ready, the collector switches to the other bank and resets fill_cnt.
  - If the other bank is not free, bytes arriving for it are dropped and overflow is set to 1.
  - rx_valid in the same cycle as the timeout: the byte goes into the current bank, and the flush is deferred by one cycle.
- Idle counter resets on every rx_valid and saturates at IDLE_TIMEOUT.
- Writer FSM:
  - S_IDLE: no action until start. On start: wr_addr <= {start_addr[23:8], 8'h00}, first_page <= 1, overflow <= 0, bytes_written <= 0, banks free, go to S_WAIT.
  - S_WAIT: when the oldest ready bank exists, go to S_ERASE if first_page or wr_addr[SECTOR_BITS-1:0] == 0; otherwise go to S_PROG.
  - S_ERASE: assert flash_sector_erase with flash_sector_addr = wr_addr. On ack, deassert in the same edge, clear first_page, go to S_PROG.
  - S_PROG: assert flash_write with flash_write_addr = wr_addr and flash_write_size = bank count. Each flash_write_data_req cycle registers the next bank byte onto flash_write_data_in at the following edge (byte k after the (k+1)th req). On ack, deassert, free the bank, add the count to bytes_written, go to S_NEXT.
  - S_NEXT: wr_addr <= wr_addr + 256, wrapping mod 2^24 (FFFF00 -> 000000). Go to S_WAIT.
- Requests never drop before their ack. Erase and write are never asserted together.
- A start pulse while busy is ignored.
- Reset mid-operation drops all requests to 0 immediately; buffer contents are discarded.
- A partial page only restarts on the next page boundary; a short flush never leaves wr_addr unaligned.

Decomposition:
- Shared package: state encodings (S_IDLE, S_WAIT, S_ERASE, S_PROG, S_NEXT), PAGE_SIZE = 256, the bank-state codes (free, filling, ready).
- Sub-module loader_page_ram: 512x8 simple dual-port RAM with synchronous read. The bank select is address bit 8.

Test Plan:
- start_addr = 0x012345, then 256 bytes 0x00..0xFF -> one erase at 0x012300, one program at 0x012300 with size 256 and data 0x00..0xFF in order; bytes_written = 256.
- start_addr = 0x000F00, then 512 bytes -> erase at 0x000F00, program at 0x000F00, erase at 0x001000, program at 0x001000; no other erases.
- 10 bytes, then silence for IDLE_TIMEOUT cycles -> program with size 10 at start_addr; busy falls after ack; bytes_written = 10.
- Flash model holds erase ack off for 100k cycles while 600 bytes stream in back to back -> bytes 0..511 are programmed correctly, the following bytes are dropped, overflow = 1; the next start clears overflow.
- start_addr = 0xFFFF00, then 512 bytes -> program at 0xFFFF00, then erase and program at 0x000000.
- rst_n asserted during S_PROG after 100 data requests -> flash_write = 0 asynchronously, busy = 0, state S_IDLE; a new session then completes normally.
